ext_pipe: RTL and testbench

Parametrised, pipelined immediate extender for the MIPS32 decode/execute boundary. It accepts an immediate with an extension-mode code and a tag over a valid/ready handshake. It produces the widened immediate (zero, sign, upper-placed, or branch-offset form) from a small output buffer, so decode can run ahead of an execute-stage stall. Flush support lets branch/exception redirects discard in-flight immediates.

---
 rtl/ext_pipe.sv | 160 ++++++++++++++++
 tb/tb_ext_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_pipe.sv
// ext_pipe: pipelined MIPS32 immediate extender with a small output buffer.
// The immediate is widened combinationally at the input (zero, sign, upper,
// branch-offset or ones form) and stored with its tag in a circular buffer.
// Decode can therefore run ahead while execute is stalled.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   flush               discard all buffered entries and this cycle's input
//   in_valid/in_ready   input handshake (in_ready is a flop, derived from count)
//   ext_op, imm_in,     extension mode, raw immediate and sideband tag
//   tag_in
//   out_valid/out_ready output handshake for the head entry (out_valid is a flop)
//   imm_out, tag_out,   head entry: extended immediate, tag, illegal-op flag
//   bad_op
module ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ext_op,
  input  logic [IN_W-1:0]  imm_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] imm_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             bad_op
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int XW = OUT_W - IN_W;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Returns {bad_op, extended value}; illegal modes give a zero value.
  function automatic logic [OUT_W:0] extend_imm(input logic [2:0] op,
                                                input logic [IN_W-1:0] imm);
    logic [OUT_W-1:0] sx;
    logic [OUT_W:0]   r;
    sx = {{XW{imm[IN_W-1]}}, imm};
    case (op)
      3'b000:  r = {1'b0, {XW{1'b0}}, imm};
      3'b001:  r = {1'b0, sx};
      3'b010:  r = {1'b0, imm, {XW{1'b0}}};
      // Branch offset: the two bits shifted out of the top are dropped.
      3'b011:  r = {1'b0, sx[OUT_W-3:0], 2'b00};
      3'b100:  r = {1'b0, {XW{1'b1}}, imm};
      default: r = {1'b1, {OUT_W{1'b0}}};
    endcase
    return r;
  endfunction

  // Pointer advance with explicit wrap, so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == LAST_PTR) begin
      n = {PW{1'b0}};
    end else begin
      n = p + PW'(1);
    end
    return n;
  endfunction

  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] imm_mem_q [DEPTH];
  logic [OUT_W-1:0] imm_mem_d [DEPTH];
  logic [TAG_W-1:0] tag_mem_q [DEPTH];
  logic [TAG_W-1:0] tag_mem_d [DEPTH];
  logic             bad_mem_q [DEPTH];
  logic             bad_mem_d [DEPTH];
  logic [OUT_W:0]   ext_s;
  logic             push_s;
  logic             pop_s;

  // Handshake decode uses only the registered ready/valid flags.
  assign push_s = in_valid && in_ready_q && !flush;
  assign pop_s  = out_valid_q && out_ready && !flush;

  // Next-state: buffer write, pointer advance, occupancy and flag decode.
  always_comb begin
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    imm_mem_d = imm_mem_q;
    tag_mem_d = tag_mem_q;
    bad_mem_d = bad_mem_q;
    ext_s     = extend_imm(ext_op, imm_in);
    if (flush) begin
      count_d  = {CW{1'b0}};
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
    end else begin
      if (push_s) begin
        imm_mem_d[wr_ptr_q] = ext_s[OUT_W-1:0];
        tag_mem_d[wr_ptr_q] = tag_in;
        bad_mem_d[wr_ptr_q] = ext_s[OUT_W];
        wr_ptr_d            = next_ptr(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_s && !pop_s) begin
        count_d = count_q + CW'(1);
      end else if (pop_s && !push_s) begin
        count_d = count_q - CW'(1);
      end else begin
        count_d = count_q;
      end
    end
    in_ready_d  = (count_d != FULL_CNT);
    out_valid_d = (count_d != {CW{1'b0}});
  end

  // State registers; reset clears every entry so head outputs read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= {CW{1'b0}};
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        imm_mem_q[i] <= {OUT_W{1'b0}};
        tag_mem_q[i] <= {TAG_W{1'b0}};
        bad_mem_q[i] <= 1'b0;
      end
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      imm_mem_q   <= imm_mem_d;
      tag_mem_q   <= tag_mem_d;
      bad_mem_q   <= bad_mem_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign imm_out   = imm_mem_q[rd_ptr_q];
  assign tag_out   = tag_mem_q[rd_ptr_q];
  assign bad_op    = bad_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: directed checks on a default ext_pipe (16->32, DEPTH=2) plus a
// random sweep on a 12->20, DEPTH=3 instance against a reference queue.
module tb_ext_pipe;

  logic clk;
  logic rst;

  // Instance A: IN_W=16, OUT_W=32, DEPTH=2, TAG_W=5
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_bad_op;
  logic [2:0]  a_ext_op;
  logic [15:0] a_imm_in;
  logic [4:0]  a_tag_in, a_tag_out;
  logic [31:0] a_imm_out;

  // Instance B: IN_W=12, OUT_W=20, DEPTH=3, TAG_W=5
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_bad_op;
  logic [2:0]  b_ext_op;
  logic [11:0] b_imm_in;
  logic [4:0]  b_tag_in, b_tag_out;
  logic [19:0] b_imm_out;

  int n_checks;
  int n_fail;

  typedef struct packed {
    logic [19:0] imm;
    logic [4:0]  tag;
    logic        bad;
  } ent_t;

  ent_t model_q[$];

  ext_pipe dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .ext_op(a_ext_op), .imm_in(a_imm_in), .tag_in(a_tag_in),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .imm_out(a_imm_out), .tag_out(a_tag_out), .bad_op(a_bad_op)
  );

  ext_pipe #(.IN_W(12), .OUT_W(20), .DEPTH(3), .TAG_W(5)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .ext_op(b_ext_op), .imm_in(b_imm_in), .tag_in(b_tag_in),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .imm_out(b_imm_out), .tag_out(b_tag_out), .bad_op(b_bad_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic [2:0] op,
                         input logic [15:0] imm, input logic [4:0] tag);
    a_in_valid = v;
    a_ext_op   = op;
    a_imm_in   = imm;
    a_tag_in   = tag;
  endtask

  // Hand-written 12->20 extension reference.
  function automatic ent_t ref12(input logic [2:0] op, input logic [11:0] imm,
                                 input logic [4:0] tag);
    ent_t e;
    logic [19:0] sx;
    sx    = {{8{imm[11]}}, imm};
    e.tag = tag;
    e.bad = 1'b0;
    case (op)
      3'd0:    e.imm = {8'h00, imm};
      3'd1:    e.imm = sx;
      3'd2:    e.imm = {imm, 8'h00};
      3'd3:    e.imm = {sx[17:0], 2'b00};
      3'd4:    e.imm = {8'hFF, imm};
      default: begin e.imm = 20'h0; e.bad = 1'b1; end
    endcase
    return e;
  endfunction

  initial begin
    logic [2:0]  mode_op  [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] mode_imm [8] = '{32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004,
                                  32'hFFFF8001, 32'h0, 32'h0, 32'h0};
    logic        mode_bad [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int   accepted;
    int   cycles;
    logic do_pop;
    logic do_push;
    ent_t head;

    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    a_flush = 1'b0; a_out_ready = 1'b0;
    a_drive(1'b0, 3'd0, 16'h0, 5'd0);
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    b_ext_op = 3'd0; b_imm_in = 12'h0; b_tag_in = 5'd0;

    // Reset state
    #1;
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_in_ready",  64'(a_in_ready),  64'd1);
    chk("rst_imm_out",   64'(a_imm_out),   64'd0);
    chk("rst_tag_out",   64'(a_tag_out),   64'd0);
    chk("rst_bad_op",    64'(a_bad_op),    64'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // Extension modes: with out_ready=1 each beat is the head one edge later
    a_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_drive(1'b1, mode_op[i], 16'h8001, 5'(i));
      step();
      chk("mode_valid", 64'(a_out_valid), 64'd1);
      chk("mode_ready", 64'(a_in_ready),  64'd1);
      chk("mode_imm",   64'(a_imm_out),   64'(mode_imm[i]));
      chk("mode_bad",   64'(a_bad_op),    64'(mode_bad[i]));
      chk("mode_tag",   64'(a_tag_out),   64'(i));
    end
    a_drive(1'b1, 3'd1, 16'h7FFF, 5'd9);
    step();
    chk("sext_pos_imm", 64'(a_imm_out), 64'h00007FFF);
    chk("sext_pos_bad", 64'(a_bad_op),  64'd0);
    a_drive(1'b0, 3'd0, 16'h0, 5'd0);
    step();
    chk("drain_valid", 64'(a_out_valid), 64'd0);

    // Backpressure: tags 1,2,3 with out_ready=0
    a_out_ready = 1'b0;
    a_drive(1'b1, 3'd0, 16'h0001, 5'd1);
    step();
    chk("bp1_ready", 64'(a_in_ready), 64'd1);
    chk("bp1_tag",   64'(a_tag_out),  64'd1);
    a_drive(1'b1, 3'd0, 16'h0002, 5'd2);
    step();
    chk("bp2_ready", 64'(a_in_ready), 64'd0);
    chk("bp2_tag",   64'(a_tag_out),  64'd1);
    a_drive(1'b1, 3'd0, 16'h0003, 5'd3);
    step();
    chk("bp3_ready", 64'(a_in_ready), 64'd0);
    chk("bp3_tag",   64'(a_tag_out),  64'd1);
    chk("bp3_imm",   64'(a_imm_out),  64'h1);
    a_out_ready = 1'b1;       // full + in_valid: pop only
    step();
    chk("bpfull_ready", 64'(a_in_ready),  64'd1);
    chk("bpfull_valid", 64'(a_out_valid), 64'd1);
    chk("bpfull_tag",   64'(a_tag_out),   64'd2);
    step();                   // count 1: push 3, pop 2
    chk("bpsim_ready", 64'(a_in_ready), 64'd1);
    chk("bpsim_tag",   64'(a_tag_out),  64'd3);
    chk("bpsim_imm",   64'(a_imm_out),  64'h3);
    a_drive(1'b0, 3'd0, 16'h0, 5'd0);
    step();
    chk("bp_drain_valid", 64'(a_out_valid), 64'd0);

    // Flush with full buffer and input present
    a_out_ready = 1'b0;
    a_drive(1'b1, 3'd0, 16'h0004, 5'd4);
    step();
    a_drive(1'b1, 3'd0, 16'h0005, 5'd5);
    step();
    chk("fl_full_ready", 64'(a_in_ready), 64'd0);
    a_drive(1'b1, 3'd0, 16'h0006, 5'd6);
    a_flush = 1'b1;
    step();
    chk("fl_valid", 64'(a_out_valid), 64'd0);
    chk("fl_ready", 64'(a_in_ready),  64'd1);
    a_flush = 1'b0;
    a_drive(1'b0, 3'd0, 16'h0, 5'd0);
    step();
    chk("fl_after_valid", 64'(a_out_valid), 64'd0);
    // Flush with one entry, input would otherwise be accepted
    a_drive(1'b1, 3'd0, 16'h0007, 5'd7);
    step();
    a_drive(1'b1, 3'd0, 16'h0008, 5'd8);
    a_flush = 1'b1;
    step();
    chk("fl1_valid", 64'(a_out_valid), 64'd0);
    a_flush = 1'b0;
    a_drive(1'b0, 3'd0, 16'h0, 5'd0);
    step();
    chk("fl1_after_valid", 64'(a_out_valid), 64'd0);
    a_drive(1'b1, 3'd1, 16'hF000, 5'd12);
    step();
    a_drive(1'b0, 3'd0, 16'h0, 5'd0);
    chk("fl_new_valid", 64'(a_out_valid), 64'd1);
    chk("fl_new_tag",   64'(a_tag_out),   64'd12);
    chk("fl_new_imm",   64'(a_imm_out),   64'hFFFFF000);
    a_out_ready = 1'b1;
    step();
    chk("fl_new_drain", 64'(a_out_valid), 64'd0);

    // Async reset between edges with two entries buffered
    a_out_ready = 1'b0;
    a_drive(1'b1, 3'd2, 16'h1111, 5'd9);
    step();
    a_drive(1'b1, 3'd2, 16'h2222, 5'd10);
    step();
    a_drive(1'b0, 3'd0, 16'h0, 5'd0);
    chk("ar_full_ready", 64'(a_in_ready), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", 64'(a_out_valid), 64'd0);
    chk("ar_ready", 64'(a_in_ready),  64'd1);
    chk("ar_imm",   64'(a_imm_out),   64'd0);
    chk("ar_tag",   64'(a_tag_out),   64'd0);
    chk("ar_bad",   64'(a_bad_op),    64'd0);
    rst = 1'b0;
    a_drive(1'b1, 3'd0, 16'h1234, 5'd11);
    step();
    a_drive(1'b0, 3'd0, 16'h0, 5'd0);
    chk("ar_new_valid", 64'(a_out_valid), 64'd1);
    chk("ar_new_tag",   64'(a_tag_out),   64'd11);
    chk("ar_new_imm",   64'(a_imm_out),   64'h00001234);

    // Random sweep on instance B against a reference queue
    accepted = 0;
    cycles   = 0;
    while (accepted < 1000 && cycles < 20000) begin
      chk("sw_valid", 64'(b_out_valid), 64'(model_q.size() != 0));
      chk("sw_ready", 64'(b_in_ready),  64'(model_q.size() != 3));
      if (model_q.size() != 0) begin
        head = model_q[0];
        chk("sw_imm", 64'(b_imm_out), 64'(head.imm));
        chk("sw_tag", 64'(b_tag_out), 64'(head.tag));
        chk("sw_bad", 64'(b_bad_op),  64'(head.bad));
      end
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 2) != 0);
      b_flush     = ($urandom_range(0, 63) == 0);
      b_ext_op    = 3'($urandom_range(0, 7));
      b_imm_in    = 12'($urandom);
      b_tag_in    = 5'($urandom);
      if (b_flush) begin
        model_q.delete();
      end else begin
        do_pop  = b_out_ready && (model_q.size() != 0);
        do_push = b_in_valid && (model_q.size() != 3);
        if (do_pop) begin
          void'(model_q.pop_front());
        end
        if (do_push) begin
          model_q.push_back(ref12(b_ext_op, b_imm_in, b_tag_in));
          accepted++;
        end
      end
      step();
      cycles++;
    end
    chk("sw_done", 64'(accepted >= 1000), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
